squeeze_output_stage: RTL and testbench
=======================================

Name: squeeze_output_stage

Overview:
- Final pipeline stage, directly downstream of the permute stage.
- Captures one rate block when the permute stage writes `output_buffer_we`, then serializes it into OUT_WIDTH-bit words on a valid/ready stream.
- Truncates the digest to the requested output length in bits.
- Drives `output_buffer_available` back to the permute stage to pace squeezing.

Parameters:
- OUT_WIDTH, 64, width of the output word in bits; legal values are 32 and 64 (both divide every rate).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- rate_input  in  RATE_SHAKE128  rate block from the permute stage; bit 0 is the first output bit.
- operation_mode_in  in  2  mode tag of the block; selects the rate length.
- output_buffer_we  in  1  one-cycle write strobe from the permute stage.
- output_buffer_available  out  1  high when the internal buffer is empty and can take a block.
- out_size_load  in  1  one-cycle pulse that starts a new message; loads the remaining-bit counter.
- out_size_in  in  32  requested output length in bits, sampled on out_size_load.
- data_out  out  OUT_WIDTH  output word.
- data_out_valid  out  1  data_out holds a valid word.
- data_out_last  out  1  qualifies the final word of the message.
- data_out_ready  in  1  downstream accepts the word this cycle.

Behaviour:
- Reset (asynchronous, while rst low):
  - state=EMPTY; output_buffer_available=1.
  - data_out_valid=0, data_out_last=0, data_out=0.
  - remaining=0, word_idx=0, buffer cleared.
- Rate words per block, from operation_mode_in captured with the block:
  - 00 SHAKE128: 1344/OUT_WIDTH.
  - 01 SHAKE256: 1088/OUT_WIDTH.
  - 10 SHA3-256: 1088/OUT_WIDTH.
  - 11 SHA3-512: 576/OUT_WIDTH.
  - Bits of rate_input above the mode's rate are ignored.
- FSM, two states:
  - EMPTY: output_buffer_available=1, data_out_valid=0. On output_buffer_we, capture rate_input and mode, set word_idx=0, and go to DRAIN.
  - DRAIN: output_buffer_available=0, data_out_valid=1.
    - data_out = buffer word word_idx, with bits at positions >= remaining forced to 0.
    - data_out_last = (remaining <= OUT_WIDTH).
- Transfer: a word transfers on a cycle where data_out_valid and data_out_ready are both high.
  - On transfer, remaining = remaining - OUT_WIDTH, saturating at 0, and word_idx increments.
  - If the word had data_out_last set, or word_idx was words_per_block-1, the state returns to EMPTY. Any unsent words of the block are discarded.
- Latency and throughput:
  - output_buffer_we at cycle n: data_out_valid=1 and output_buffer_available=0 at cycle n+1.
  - With ready held high, one word per cycle.
  - Final transfer at cycle m: output_buffer_available=1 at cycle m+1. A new output_buffer_we is accepted at m+1.
  - No same-cycle bypass from write to output.
- Data stability: while data_out_valid=1 and data_out_ready=0, data_out and data_out_last are held stable.
- out_size_load:
  - Honoured only in EMPTY.
  - In DRAIN it is ignored, and an assertion fires.
  - If coincident with output_buffer_we in EMPTY, the load takes effect first, so the block uses the new size.
- Zero length: if remaining=0 when a block is captured, the block is dropped. The FSM returns to EMPTY the next cycle, no word is emitted, and output_buffer_available is low for exactly one cycle.
- output_buffer_we while in DRAIN is a protocol violation: it is ignored, the buffer is unchanged, and an assertion fires.
- Reset mid-DRAIN: outputs return to their reset values immediately; the partial message is lost.
- Truncation granularity is bits: the final word carries (remaining mod OUT_WIDTH) valid low bits, or a full word when the remainder is 0.

Decomposition:
- keccak_pkg gains:
  - mode encodings MODE_SHAKE128, MODE_SHAKE256, MODE_SHA3_256, MODE_SHA3_512;
  - rate constants RATE_SHAKE256=1088, RATE_SHA3_512=576;
  - function rate_words(mode, width).
- Sub-module squeeze_fsm holds the EMPTY/DRAIN control, the handshake, and the counter enables.
- The buffer, word mux and mask stay in a squeeze_datapath. This matches the fsm/datapath split used by the other stages.

Test Plan:
- SHAKE128, out_size_in=256, one block written, ready held high:
  - exactly 4 words equal to rate_input[255:0] in order;
  - last on the 4th word;
  - available reasserted the cycle after the 4th transfer.
- SHAKE256, out_size_in=2176 (two blocks):
  - 17 words from block 1, available=1, then 17 words from block 2;
  - last only on word 34.
- SHAKE128, out_size_in=100:
  - word 0 is the full 64 bits;
  - word 1 carries 36 valid bits with bits [63:36]=0, and last=1;
  - the remaining 19 words are discarded and available=1 the next cycle.
- Backpressure: ready toggles 1,0,0,1 during DRAIN:
  - data_out and last are held stable through the low cycles;
  - the word count is unchanged versus the ready-high run.
- out_size_in=0 and a block written:
  - no data_out_valid at all;
  - available low for exactly 1 cycle.
- Reset asserted two words into a 21-word block:
  - valid=0, last=0, available=1 immediately;
  - after release, a new SHA3-512 block with out_size_in=512 yields 8 words and last on word 8.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak pipeline definitions: mode tags, rate sizes and squeeze FSM states.
package keccak_pkg;

  typedef enum logic [1:0] {
    MODE_SHAKE128 = 2'b00,
    MODE_SHAKE256 = 2'b01,
    MODE_SHA3_256 = 2'b10,
    MODE_SHA3_512 = 2'b11
  } mode_e;

  localparam int unsigned RATE_SHAKE128 = 1344;
  localparam int unsigned RATE_SHAKE256 = 1088;
  localparam int unsigned RATE_SHA3_256 = 1088;
  localparam int unsigned RATE_SHA3_512 = 576;

  typedef enum logic {
    EMPTY,
    DRAIN
  } squeeze_state_e;

  function automatic int unsigned rate_words(input mode_e mode, input int unsigned width);
    int unsigned bits;
    case (mode)
      MODE_SHAKE128: bits = RATE_SHAKE128;
      MODE_SHAKE256: bits = RATE_SHAKE256;
      MODE_SHA3_256: bits = RATE_SHA3_256;
      default:       bits = RATE_SHA3_512;
    endcase
    return bits / width;
  endfunction

endpackage

// File: rtl/squeeze_output_stage_if.sv
// Permute-stage block write, message length load and output word stream of the squeeze stage.
interface squeeze_output_stage_if #(
  parameter int unsigned OUT_WIDTH = 64
);
  logic [keccak_pkg::RATE_SHAKE128-1:0] rate_input;
  logic [1:0]                           operation_mode_in;
  logic                                 output_buffer_we;
  logic                                 output_buffer_available;
  logic                                 out_size_load;
  logic [31:0]                          out_size_in;
  logic [OUT_WIDTH-1:0]                 data_out;
  logic                                 data_out_valid;
  logic                                 data_out_last;
  logic                                 data_out_ready;

  modport master (
    output rate_input, operation_mode_in, output_buffer_we, out_size_load, out_size_in,
    output data_out_ready,
    input  output_buffer_available, data_out, data_out_valid, data_out_last
  );

  modport slave (
    input  rate_input, operation_mode_in, output_buffer_we, out_size_load, out_size_in,
    input  data_out_ready,
    output output_buffer_available, data_out, data_out_valid, data_out_last
  );
endinterface

// File: rtl/squeeze_datapath.sv
// Rate block buffer, remaining-bit and word counters, word select and bit-level truncation mask.
module squeeze_datapath
  import keccak_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RATE_SHAKE128-1:0] rate_input,
  input  logic [1:0]               operation_mode_in,
  input  logic [31:0]              out_size_in,
  input  logic                     capture_en,
  input  logic                     size_load_en,
  input  logic                     xfer_en,
  input  logic                     data_out_valid,
  output logic [OUT_WIDTH-1:0]     data_out,
  output logic                     data_out_last,
  output logic                     last_word,
  output logic                     remaining_zero,
  output logic                     final_idx
);

  localparam int unsigned WORDS_MAX = RATE_SHAKE128 / OUT_WIDTH;
  localparam int unsigned IDX_W     = $clog2(WORDS_MAX + 1);
  localparam int unsigned SH_W      = $clog2(OUT_WIDTH);
  localparam logic [OUT_WIDTH-1:0] ONES = '1;

  logic [WORDS_MAX-1:0][OUT_WIDTH-1:0] buf_q;
  mode_e                               mode_q;
  logic [31:0]                         remaining_q;
  logic [IDX_W-1:0]                    word_idx_q;
  logic [OUT_WIDTH-1:0]                word_sel;
  logic [OUT_WIDTH-1:0]                mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q       <= '0;
      mode_q      <= MODE_SHAKE128;
      remaining_q <= '0;
      word_idx_q  <= '0;
    end else begin
      if (capture_en) begin
        buf_q      <= rate_input;
        mode_q     <= mode_e'(operation_mode_in);
        word_idx_q <= '0;
      end else if (xfer_en) begin
        word_idx_q <= word_idx_q + IDX_W'(1);
      end
      // last_word already means remaining <= OUT_WIDTH, so this saturates at zero.
      if (size_load_en)  remaining_q <= out_size_in;
      else if (xfer_en)  remaining_q <= last_word ? '0 : remaining_q - OUT_WIDTH;
    end
  end

  always_comb begin
    word_sel = '0;
    if (word_idx_q < IDX_W'(WORDS_MAX)) word_sel = buf_q[word_idx_q];
    mask = ONES;
    if (remaining_q < OUT_WIDTH) mask = ~(ONES << remaining_q[SH_W-1:0]);
  end

  assign last_word      = (remaining_q <= OUT_WIDTH);
  assign remaining_zero = (remaining_q == '0);
  assign final_idx      = (32'(word_idx_q) == rate_words(mode_q, OUT_WIDTH) - 1);
  assign data_out       = data_out_valid ? (word_sel & mask) : '0;
  assign data_out_last  = data_out_valid & last_word;

endmodule

// File: rtl/squeeze_fsm.sv
// EMPTY/DRAIN control for the squeeze stage: handshake, buffer capture and counter enables.
module squeeze_fsm
  import keccak_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic output_buffer_we,
  input  logic out_size_load,
  input  logic data_out_ready,
  input  logic last_word,
  input  logic remaining_zero,
  input  logic final_idx,
  output logic output_buffer_available,
  output logic data_out_valid,
  output logic capture_en,
  output logic size_load_en,
  output logic xfer_en
);

  squeeze_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d                 = state_q;
    output_buffer_available = 1'b0;
    data_out_valid          = 1'b0;
    capture_en              = 1'b0;
    size_load_en            = 1'b0;
    xfer_en                 = 1'b0;
    unique case (state_q)
      EMPTY: begin
        output_buffer_available = 1'b1;
        size_load_en            = out_size_load;
        capture_en              = output_buffer_we;
        if (output_buffer_we) state_d = DRAIN;
      end
      DRAIN: begin
        // A block captured with nothing left to send spends one cycle here and is dropped.
        data_out_valid = !remaining_zero;
        xfer_en        = data_out_valid && data_out_ready;
        if (remaining_zero || (xfer_en && (last_word || final_idx))) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  a_no_we_in_drain: assert property (@(posedge clk) disable iff (!rst)
    (state_q == DRAIN) |-> !output_buffer_we)
    else $error("output_buffer_we asserted while draining");

  a_no_load_in_drain: assert property (@(posedge clk) disable iff (!rst)
    (state_q == DRAIN) |-> !out_size_load)
    else $error("out_size_load asserted while draining");

endmodule

// File: rtl/squeeze_output_stage.sv
// Final Keccak stage: captures a rate block and streams it out as truncated OUT_WIDTH-bit words.
module squeeze_output_stage
  import keccak_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 64
) (
  input logic                   clk,
  input logic                   rst,
  squeeze_output_stage_if.slave bus
);

  logic capture_en;
  logic size_load_en;
  logic xfer_en;
  logic last_word;
  logic remaining_zero;
  logic final_idx;
  logic valid;

  squeeze_fsm u_fsm (
    .clk                     (clk),
    .rst                     (rst),
    .output_buffer_we        (bus.output_buffer_we),
    .out_size_load           (bus.out_size_load),
    .data_out_ready          (bus.data_out_ready),
    .last_word               (last_word),
    .remaining_zero          (remaining_zero),
    .final_idx               (final_idx),
    .output_buffer_available (bus.output_buffer_available),
    .data_out_valid          (valid),
    .capture_en              (capture_en),
    .size_load_en            (size_load_en),
    .xfer_en                 (xfer_en)
  );

  squeeze_datapath #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_dp (
    .clk               (clk),
    .rst               (rst),
    .rate_input        (bus.rate_input),
    .operation_mode_in (bus.operation_mode_in),
    .out_size_in       (bus.out_size_in),
    .capture_en        (capture_en),
    .size_load_en      (size_load_en),
    .xfer_en           (xfer_en),
    .data_out_valid    (valid),
    .data_out          (bus.data_out),
    .data_out_last     (bus.data_out_last),
    .last_word         (last_word),
    .remaining_zero    (remaining_zero),
    .final_idx         (final_idx)
  );

  assign bus.data_out_valid = valid;

endmodule

// File: tb/tb_squeeze_output_stage.sv
// Randomized bench for squeeze_output_stage, checked against a per-message bit-budget model.
module tb_squeeze_output_stage;

  localparam int W  = 64;
  localparam int RB = 1344;

  typedef logic [RB/W-1:0][W-1:0] block_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  squeeze_output_stage_if #(.OUT_WIDTH(W)) bus ();

  squeeze_output_stage #(.OUT_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  int unsigned model_rem;
  logic [W-1:0] exp_d[$];
  bit           exp_l[$];
  logic [W-1:0] obs_d[$];
  bit           obs_l[$];
  int avail_low, nvalid, hold_viol;
  bit timed_out, first_valid;

  function automatic int unsigned rate_bits(input logic [1:0] m);
    case (m)
      2'b00:        return 1344;
      2'b01, 2'b10: return 1088;
      default:      return 576;
    endcase
  endfunction

  // Model: a message is a bit budget; each block contributes up to its rate, low bits first.
  function automatic void model_block(input block_t blk, input logic [1:0] m);
    int unsigned n;
    logic [W-1:0] w;
    for (int k = 0; k < int'(rate_bits(m) / W); k++) begin
      if (model_rem == 0) break;
      w = blk[5'(k)];
      n = (model_rem >= W) ? W : model_rem;
      if (n < W) w = w & ((64'd1 << n) - 64'd1);
      exp_d.push_back(w);
      exp_l.push_back(model_rem <= W);
      model_rem = model_rem - n;
    end
  endfunction

  function automatic block_t rand_block();
    block_t b;
    for (int i = 0; i < RB / W; i++) b[5'(i)] = {$urandom(), $urandom()};
    return b;
  endfunction

  task automatic clear_queues();
    exp_d.delete(); exp_l.delete(); obs_d.delete(); obs_l.delete();
  endtask

  // Called at a negedge with the stage EMPTY; returns one negedge later.
  task automatic write_block(input block_t blk, input logic [1:0] m, input bit load,
                             input logic [31:0] size);
    bus.rate_input        = blk;
    bus.operation_mode_in = m;
    bus.output_buffer_we  = 1'b1;
    bus.out_size_load     = load;
    bus.out_size_in       = size;
    if (load) model_rem = size;
    model_block(blk, m);
    @(negedge clk);
    bus.output_buffer_we = 1'b0;
    bus.out_size_load    = 1'b0;
  endtask

  // ready_mode: 0 always high, 1 random, 2 repeating 1,0,0,1. Stops when available returns.
  task automatic drain(input int ready_mode, input int budget);
    int cyc;
    bit pv, pr, pl, r, v;
    logic [W-1:0] pd;
    avail_low = 0; nvalid = 0; hold_viol = 0; timed_out = 0; cyc = 0;
    pv = 0; pr = 0; pl = 0; pd = '0;
    first_valid = bus.data_out_valid;
    forever begin
      if (bus.output_buffer_available) break;
      if (cyc >= budget) begin timed_out = 1; break; end
      avail_low++;
      v = bus.data_out_valid;
      if (pv && !pr && !(v && bus.data_out === pd && bus.data_out_last === pl)) hold_viol++;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) != 0);
        default: r = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      bus.data_out_ready = r;
      if (v) nvalid++;
      if (v && r) begin
        obs_d.push_back(bus.data_out);
        obs_l.push_back(bus.data_out_last);
      end
      pv = v; pr = r; pd = bus.data_out; pl = bus.data_out_last;
      cyc++;
      @(negedge clk);
    end
    bus.data_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (bus.output_buffer_available !== 1'b1) begin miscompares++;
      $display("FAIL reset_available got=%0b exp=1", bus.output_buffer_available); end
    vectors++;
    if (bus.data_out_valid !== 1'b0 || bus.data_out_last !== 1'b0) begin miscompares++;
      $display("FAIL reset_valid_last got=%0b/%0b exp=0/0", bus.data_out_valid, bus.data_out_last); end
    vectors++;
    if (bus.data_out !== '0) begin miscompares++;
      $display("FAIL reset_data got=%h exp=0", bus.data_out); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_shake128_256();
    block_t b = rand_block();
    clear_queues();
    write_block(b, 2'b00, 1'b1, 256);
    drain(0, 100);
    vectors++;
    if (timed_out || !first_valid) begin miscompares++;
      $display("FAIL s128_latency timeout=%0b first_valid=%0b exp=0/1", timed_out, first_valid); end
    vectors++;
    if (obs_d.size() != 4) begin miscompares++;
      $display("FAIL s128_count got=%0d exp=4", obs_d.size()); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      vectors++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_d[i] !== b[5'(i)]) begin miscompares++;
        $display("FAIL s128_word%0d got=%h/%0b exp=%h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]); end
    end
    vectors++;
    if (avail_low != 4) begin miscompares++;
      $display("FAIL s128_avail_low got=%0d exp=4", avail_low); end
  endtask

  task automatic test_two_blocks();
    block_t b1 = rand_block();
    block_t b2 = rand_block();
    int lasts;
    clear_queues();
    write_block(b1, 2'b01, 1'b1, 2176);
    drain(0, 100);
    vectors++;
    if (timed_out || obs_d.size() != 17 || bus.output_buffer_available !== 1'b1) begin miscompares++;
      $display("FAIL two_blk_first got=%0d words avail=%0b exp=17 words avail=1",
               obs_d.size(), bus.output_buffer_available); end
    write_block(b2, 2'b01, 1'b0, 0);
    drain(0, 100);
    vectors++;
    if (timed_out || obs_d.size() != 34) begin miscompares++;
      $display("FAIL two_blk_count got=%0d exp=34", obs_d.size()); end
    lasts = 0;
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      vectors++;
      if (obs_l[i]) lasts++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin miscompares++;
        $display("FAIL two_blk_word%0d got=%h/%0b exp=%h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]); end
    end
    vectors++;
    if (lasts != 1) begin miscompares++;
      $display("FAIL two_blk_last_count got=%0d exp=1", lasts); end
  endtask

  task automatic test_truncate_100();
    block_t b = rand_block();
    clear_queues();
    write_block(b, 2'b00, 1'b1, 100);
    drain(0, 100);
    vectors++;
    if (timed_out || obs_d.size() != 2 || avail_low != 2) begin miscompares++;
      $display("FAIL trunc_shape got=%0d words %0d busy exp=2 words 2 busy", obs_d.size(), avail_low); end
    if (obs_d.size() == 2) begin
      vectors++;
      if (obs_d[0] !== b[0] || obs_l[0] !== 1'b0) begin miscompares++;
        $display("FAIL trunc_word0 got=%h/%0b exp=%h/0", obs_d[0], obs_l[0], b[0]); end
      vectors++;
      if (obs_d[1] !== (b[1] & 64'h0000_000F_FFFF_FFFF) || obs_l[1] !== 1'b1) begin miscompares++;
        $display("FAIL trunc_word1 got=%h/%0b exp=%h/1", obs_d[1], obs_l[1], b[1] & 64'h0000_000F_FFFF_FFFF); end
    end
  endtask

  task automatic test_backpressure();
    block_t b = rand_block();
    clear_queues();
    write_block(b, 2'b00, 1'b1, 256);
    drain(2, 100);
    vectors++;
    if (timed_out || obs_d.size() != 4 || avail_low <= 4) begin miscompares++;
      $display("FAIL bp_shape got=%0d words %0d busy exp=4 words >4 busy", obs_d.size(), avail_low); end
    vectors++;
    if (hold_viol != 0) begin miscompares++;
      $display("FAIL bp_hold got=%0d unstable cycles exp=0", hold_viol); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      vectors++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin miscompares++;
        $display("FAIL bp_word%0d got=%h/%0b exp=%h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_zero_length();
    block_t b = rand_block();
    clear_queues();
    write_block(b, 2'b00, 1'b1, 0);
    drain(0, 20);
    vectors++;
    if (timed_out || nvalid != 0 || exp_d.size() != 0) begin miscompares++;
      $display("FAIL zero_valid got=%0d valid cycles exp=0", nvalid); end
    vectors++;
    if (avail_low != 1) begin miscompares++;
      $display("FAIL zero_avail_low got=%0d exp=1", avail_low); end
  endtask

  task automatic test_reset_mid_drain();
    block_t b = rand_block();
    block_t b2 = rand_block();
    clear_queues();
    write_block(b, 2'b00, 1'b1, 1344);
    bus.data_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.data_out_valid !== 1'b1 || bus.data_out !== b[2]) begin miscompares++;
      $display("FAIL rst_mid_pre got=%0b/%h exp=1/%h", bus.data_out_valid, bus.data_out, b[2]); end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.data_out_valid !== 1'b0 || bus.data_out_last !== 1'b0 ||
        bus.output_buffer_available !== 1'b1 || bus.data_out !== '0) begin miscompares++;
      $display("FAIL rst_mid_outputs got=v%0b l%0b a%0b d%h exp=v0 l0 a1 d0", bus.data_out_valid,
               bus.data_out_last, bus.output_buffer_available, bus.data_out); end
    @(negedge clk);
    rst = 1'b1;
    bus.data_out_ready = 1'b0;
    @(negedge clk);
    clear_queues();
    write_block(b2, 2'b11, 1'b1, 512);
    drain(0, 100);
    vectors++;
    if (timed_out || obs_d.size() != 8 || obs_l.size() != 8 || !obs_l[7]) begin miscompares++;
      $display("FAIL rst_mid_sha512 got=%0d words exp=8 with last on 8", obs_d.size()); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      vectors++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin miscompares++;
        $display("FAIL sha512_word%0d got=%h/%0b exp=%h/%0b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_random();
    for (int msg = 0; msg < 12; msg++) begin
      logic [1:0] m;
      logic [31:0] size;
      bit first;
      m = 2'($urandom_range(0, 3));
      size = 32'($urandom_range(1, 3000));
      first = 1'b1;
      clear_queues();
      do begin
        write_block(rand_block(), m, first, size);
        first = 1'b0;
        drain(1, 400);
        vectors++;
        if (timed_out || hold_viol != 0) begin miscompares++;
          $display("FAIL rand%0d_drain timeout=%0b hold=%0d exp=0/0", msg, timed_out, hold_viol); end
      end while (model_rem != 0 && !timed_out);
      vectors++;
      if (obs_d.size() != exp_d.size()) begin miscompares++;
        $display("FAIL rand%0d_count got=%0d exp=%0d", msg, obs_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
        vectors++;
        if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin miscompares++;
          $display("FAIL rand%0d_word%0d got=%h/%0b exp=%h/%0b", msg, i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]); end
      end
    end
  endtask

  initial begin
    bus.rate_input        = '0;
    bus.operation_mode_in = 2'b00;
    bus.output_buffer_we  = 1'b0;
    bus.out_size_load     = 1'b0;
    bus.out_size_in       = '0;
    bus.data_out_ready    = 1'b0;
    model_rem             = 0;
    test_reset();
    test_shake128_256();
    test_two_blocks();
    test_truncate_100();
    test_backpressure();
    test_zero_length();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
